rf_multiport: RTL

//  Parametrised multi-port architectural register file for the microcontroller datapath.
//  - N write ports, M read ports.
//  - Same-cycle write-to-read bypass.
//  - Per-register pending scoreboard for in-flight producers.
//  - Hardware clear sequence after reset: every register is zeroed before the core may use the file.

---
 rtl/rf_multiport.sv | 100 ++++++++++
 1 files changed

// File: rtl/rf_multiport.sv
// Multi-port register file with same-cycle write bypass, per-register pending
// scoreboard and a hardware clear sequence that zeroes every register after reset.
module rf_multiport #(
  parameter int DATA_W      = 32,
  parameter int REG_AMT     = 16,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  output logic                              ready,
  input  logic [READ_PORTS*$clog2(REG_AMT)-1:0]  src,
  output logic [READ_PORTS*DATA_W-1:0]      dataout,
  output logic [READ_PORTS-1:0]             rd_pend,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*$clog2(REG_AMT)-1:0] dst,
  input  logic [WRITE_PORTS*DATA_W-1:0]     datain,
  input  logic                              rsv_en,
  input  logic [$clog2(REG_AMT)-1:0]        rsv_adrs
);

  localparam int ADR_W = $clog2(REG_AMT);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADR_W-1:0]    clr_cnt;
  logic [REG_AMT-1:0]  pend;
  logic [DATA_W-1:0]   mem [REG_AMT];

  // Register 0 (when hard-wired) and addresses beyond REG_AMT are never stored or reserved.
  function automatic logic addr_ok(input logic [ADR_W-1:0] a);
    return ({1'b0, a} < (ADR_W+1)'(REG_AMT)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == ADR_W'(REG_AMT-1)) state_nxt = RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      pend    <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end else begin
        for (int j = 0; j < WRITE_PORTS; j++)
          if (wr_en[j] && addr_ok(dst[j*ADR_W +: ADR_W])) pend[dst[j*ADR_W +: ADR_W]] <= 1'b0;
        // Reserve is applied last so a newer producer outranks a same-cycle retirement.
        if (rsv_en && addr_ok(rsv_adrs)) pend[rsv_adrs] <= 1'b1;
      end
    end
  end

  // Storage is left alone while reset is held; the clear sequence defines it afterwards.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        for (int j = 0; j < WRITE_PORTS; j++)
          if (wr_en[j] && addr_ok(dst[j*ADR_W +: ADR_W]))
            mem[dst[j*ADR_W +: ADR_W]] <= datain[j*DATA_W +: DATA_W];
      end
    end
  end

  assign ready = (state == RUN);

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [ADR_W-1:0]  a;
    logic [DATA_W-1:0] d;
    logic              p;

    assign a = src[i*ADR_W +: ADR_W];

    always_comb begin
      d = '0;
      p = 1'b0;
      if (state == RUN && addr_ok(a)) begin
        d = mem[a];
        p = pend[a];
        if (BYPASS != 0)
          for (int j = 0; j < WRITE_PORTS; j++)
            if (wr_en[j] && dst[j*ADR_W +: ADR_W] == a) d = datain[j*DATA_W +: DATA_W];
      end
    end

    assign dataout[i*DATA_W +: DATA_W] = d;
    assign rd_pend[i]                  = p;
  end

endmodule
